// File: rtl/usb1bd_pa_if.sv
// Bus bundle between the protocol engine / memory unit (master) and the packet
// assembler (slave), including the UTMI TX byte stream the assembler drives.
interface usb1bd_pa_if;
  logic       send_token;
  logic [1:0] token_pid_sel;
  logic       send_data;
  logic [1:0] data_pid_sel;
  logic [7:0] tx_data_st;
  logic       tx_data_avail;
  logic       rd_next;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;

  // Handshake: a TX byte transfers on a clock where tx_valid & tx_ready are both 1;
  // while tx_valid & !tx_ready the byte on tx_data is held unchanged, and rd_next
  // only pulses on the clock that a payload byte transfers.
  modport master (
    output send_token, token_pid_sel, send_data, data_pid_sel,
    output tx_data_st, tx_data_avail, tx_ready,
    input  rd_next, tx_data, tx_valid, tx_busy, tx_done
  );

  modport slave (
    input  send_token, token_pid_sel, send_data, data_pid_sel,
    input  tx_data_st, tx_data_avail, tx_ready,
    output rd_next, tx_data, tx_valid, tx_busy, tx_done
  );
endinterface

// File: rtl/usb1bd_pa.sv
// USB1 packet assembler: emits handshake packets or PID + payload + CRC16 data
// packets onto the UTMI TX byte interface, followed by an inter-packet gap.
module usb1bd_crc16 (
  input  logic [15:0] i_crc,
  input  logic [7:0]  i_din,
  output logic [15:0] o_crc
);
  logic [15:0] w_c;

  // MSB-first CRC16 (poly 8005); i_din[7] is the first bit on the wire.
  always_comb begin
    w_c = i_crc;
    for (int i = 7; i >= 0; i--) begin
      if (w_c[15] ^ i_din[i]) w_c = {w_c[14:0], 1'b0} ^ 16'h8005;
      else                    w_c = {w_c[14:0], 1'b0};
    end
    o_crc = w_c;
  end
endmodule

module usb1bd_pa #(
  parameter int IPG_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  usb1bd_pa_if.slave  bus,
  output logic [2:0]  o_dbg_state
);
  localparam int CW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PID  = 3'd1,
    S_DATA = 3'd2,
    S_CRC1 = 3'd3,
    S_CRC2 = 3'd4,
    S_WAIT = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_pid;
  logic          r_is_data;
  logic [15:0]   r_crc;
  logic [CW-1:0] r_ipg_cnt;

  logic [7:0]    w_din_rev;
  logic [15:0]   w_crc_next;
  logic [15:0]   w_crc_val;
  logic [7:0]    w_tok_pid;
  logic [7:0]    w_dat_pid;
  logic          w_valid;
  logic [7:0]    w_data;
  logic          w_rd_next;
  logic          w_done;

  function automatic logic [7:0] pid_byte(input logic [3:0] p);
    return {~p, p};
  endfunction

  always_comb begin
    unique case (bus.token_pid_sel)
      2'b00:   w_tok_pid = pid_byte(4'h2);
      2'b01:   w_tok_pid = pid_byte(4'hA);
      2'b10:   w_tok_pid = pid_byte(4'hE);
      default: w_tok_pid = pid_byte(4'h6);
    endcase
    unique case (bus.data_pid_sel)
      2'b00:   w_dat_pid = pid_byte(4'h3);
      2'b01:   w_dat_pid = pid_byte(4'hB);
      2'b10:   w_dat_pid = pid_byte(4'h7);
      default: w_dat_pid = pid_byte(4'hF);
    endcase
  end

  // Payload is fed LSB-first into the MSB-first CRC, as the receive path does.
  always_comb begin
    for (int i = 0; i < 8; i++) w_din_rev[i] = bus.tx_data_st[7-i];
    for (int i = 0; i < 16; i++) w_crc_val[i] = ~r_crc[15-i];
  end

  usb1bd_crc16 u_crc16 (
    .i_crc (r_crc),
    .i_din (w_din_rev),
    .o_crc (w_crc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pid     <= 8'h00;
      r_is_data <= 1'b0;
      r_crc     <= 16'hffff;
      r_ipg_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        if (bus.send_token) begin
          r_pid     <= w_tok_pid;
          r_is_data <= 1'b0;
          r_crc     <= 16'hffff;
        end else if (bus.send_data) begin
          r_pid     <= w_dat_pid;
          r_is_data <= 1'b1;
          r_crc     <= 16'hffff;
        end
      end
      if (w_rd_next) r_crc <= w_crc_next;
      if (r_state == S_WAIT) r_ipg_cnt <= r_ipg_cnt + 1'b1;
      else                   r_ipg_cnt <= '0;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_valid   = 1'b0;
    w_data    = 8'h00;
    w_rd_next = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.send_token || bus.send_data) w_next = S_PID;
      end
      S_PID: begin
        w_valid = 1'b1;
        w_data  = r_pid;
        if (bus.tx_ready) begin
          if (r_is_data) begin
            w_next = S_DATA;
          end else begin
            w_done = 1'b1;
            w_next = S_WAIT;
          end
        end
      end
      S_DATA: begin
        if (bus.tx_data_avail) begin
          w_valid   = 1'b1;
          w_data    = bus.tx_data_st;
          w_rd_next = bus.tx_ready;
        end else begin
          w_next = S_CRC1;
        end
      end
      S_CRC1: begin
        w_valid = 1'b1;
        w_data  = w_crc_val[7:0];
        if (bus.tx_ready) w_next = S_CRC2;
      end
      S_CRC2: begin
        w_valid = 1'b1;
        w_data  = w_crc_val[15:8];
        if (bus.tx_ready) begin
          w_done = 1'b1;
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_ipg_cnt == CW'(IPG_CYCLES - 1)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.tx_valid = w_valid;
  assign bus.tx_data  = w_data;
  assign bus.rd_next  = w_rd_next;
  assign bus.tx_done  = w_done;
  assign bus.tx_busy  = (r_state != S_IDLE);
  assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_usb1bd_pa.sv
// Directed bench for the USB1 packet assembler: handshakes, data packets with
// CRC16, ready stalls, request collisions and reset mid-packet.
module tb_usb1bd_pa;
  localparam int IPG = 2;
  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  usb1bd_pa_if bus();
  usb1bd_pa #(.IPG_CYCLES(IPG)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  logic [7:0] payload[$];
  int         rd_cnt, done_cnt, busy_cycles, hold_err, done_bad, mem_idx;
  bit         mem_adv, stall_en, last_busy, prev_stall;
  logic [7:0] prev_data;

  // CRC-16/USB, reflected form; result is the two bytes as sent (low first).
  function automatic logic [15:0] usb_crc(input byte_q_t d);
    logic [15:0] c = 16'hffff;
    foreach (d[i]) begin
      c = c ^ {8'h00, d[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'ha001) : (c >> 1);
    end
    return ~c;
  endfunction

  // Receive-side checker: wire bit order into an MSB-first register.
  function automatic logic [15:0] rx_residual(input byte_q_t d, input int from);
    logic [15:0] c = 16'hffff;
    logic        fb;
    for (int i = from; i < d.size(); i++)
      for (int b = 0; b < 8; b++) begin
        fb = c[15] ^ d[i][b];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    return c;
  endfunction

  task automatic drive_inputs();
    if (mem_adv) begin
      mem_idx++;
      mem_adv = 1'b0;
    end
    bus.tx_data_avail = (mem_idx < payload.size());
    bus.tx_data_st    = bus.tx_data_avail ? payload[mem_idx] : 8'h00;
    bus.tx_ready      = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
  endtask

  task automatic sample();
    if (prev_stall && (!bus.tx_valid || bus.tx_data !== prev_data)) hold_err++;
    if (bus.tx_valid && bus.tx_ready) cap_q.push_back(bus.tx_data);
    if (bus.rd_next) begin
      rd_cnt++;
      mem_adv = 1'b1;
      if (!(bus.tx_valid && bus.tx_ready)) hold_err++;
    end
    if (bus.tx_done) begin
      done_cnt++;
      if (!(bus.tx_valid && bus.tx_ready)) done_bad++;
    end
    if (bus.tx_busy) busy_cycles++;
    last_busy  = bus.tx_busy;
    prev_stall = bus.tx_valid && !bus.tx_ready;
    prev_data  = bus.tx_data;
  endtask

  // Inputs change at posedge+1, outputs are sampled at negedge.
  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive_inputs();
  endtask

  task automatic start(input bit tok, input bit dat, input logic [1:0] tsel, input logic [1:0] dsel);
    cap_q.delete();
    rd_cnt = 0; done_cnt = 0; busy_cycles = 0; hold_err = 0; done_bad = 0;
    mem_idx = 0; mem_adv = 1'b0; prev_stall = 1'b0;
    drive_inputs();
    bus.send_token = tok; bus.token_pid_sel = tsel;
    bus.send_data  = dat; bus.data_pid_sel  = dsel;
    cycle();
    bus.send_token = 1'b0;
    bus.send_data  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      cycle();
      n++;
    end while (last_busy && n < 400);
    checks++;
    if (last_busy) begin
      errors++;
      $display("FAIL wait_idle: tx_busy still %0b after %0d cycles, required 0", last_busy, n);
    end
  endtask

  task automatic test_reset();
    checks += 6;
    if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); end
    if (bus.rd_next !== 1'b0)  begin errors++; $display("FAIL reset_rd_next: got %b want 0", bus.rd_next); end
    if (bus.tx_busy !== 1'b0)  begin errors++; $display("FAIL reset_tx_busy: got %b want 0", bus.tx_busy); end
    if (bus.tx_done !== 1'b0)  begin errors++; $display("FAIL reset_tx_done: got %b want 0", bus.tx_done); end
    if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
    if (dbg_state !== 3'd0)    begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_handshake();
    logic [7:0] tok_pid[4];
    tok_pid[0] = 8'hD2; tok_pid[1] = 8'h5A; tok_pid[2] = 8'h1E; tok_pid[3] = 8'h96;
    payload.delete();
    for (int s = 0; s < 4; s++) begin
      start(1'b1, 1'b0, 2'(s), 2'b00);
      wait_idle();
      checks += 5;
      if (cap_q.size() != 1) begin errors++; $display("FAIL hs_len sel=%0d: got %0d want 1", s, cap_q.size()); end
      if (cap_q.size() > 0 && cap_q[0] !== tok_pid[s]) begin
        errors++; $display("FAIL hs_pid sel=%0d: got %h want %h", s, cap_q[0], tok_pid[s]);
      end
      if (done_cnt != 1) begin errors++; $display("FAIL hs_done sel=%0d: got %0d want 1", s, done_cnt); end
      if (done_bad != 0) begin errors++; $display("FAIL hs_done_align sel=%0d: got %0d want 0", s, done_bad); end
      if (busy_cycles != 1 + IPG) begin
        errors++; $display("FAIL hs_busy sel=%0d: got %0d want %0d", s, busy_cycles, 1 + IPG);
      end
    end
  endtask

  task automatic test_data(input string name, input logic [1:0] sel, input logic [7:0] pid,
                           input int len, input bit stalls);
    logic [15:0] crc;
    payload.delete();
    for (int i = 0; i < len; i++) payload.push_back(8'(i));
    exp_q.delete();
    exp_q.push_back(pid);
    foreach (payload[i]) exp_q.push_back(payload[i]);
    crc = usb_crc(payload);
    exp_q.push_back(crc[7:0]);
    exp_q.push_back(crc[15:8]);
    stall_en = stalls;
    start(1'b0, 1'b1, 2'b00, sel);
    wait_idle();
    stall_en = 1'b0;
    checks += 5;
    if (cap_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s_len: got %0d want %0d", name, cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL %s_byte%0d: got %h want %h", name, i, (i < cap_q.size()) ? cap_q[i] : 8'hxx, exp_q[i]);
      end
    end
    if (rd_cnt != len) begin errors++; $display("FAIL %s_rd_next: got %0d want %0d", name, rd_cnt, len); end
    if (done_cnt != 1 || done_bad != 0) begin
      errors++; $display("FAIL %s_done: got %0d (misaligned %0d) want 1", name, done_cnt, done_bad);
    end
    if (hold_err != 0) begin errors++; $display("FAIL %s_hold: got %0d violations want 0", name, hold_err); end
    if (rx_residual(cap_q, 1) !== 16'h800d) begin
      errors++; $display("FAIL %s_residual: got %h want 800d", name, rx_residual(cap_q, 1));
    end
    if (!stalls) begin
      checks++;
      if (busy_cycles != len + 4 + IPG) begin
        errors++; $display("FAIL %s_busy: got %0d want %0d", name, busy_cycles, len + 4 + IPG);
      end
    end
  endtask

  task automatic test_collision();
    payload.delete();
    start(1'b1, 1'b1, 2'b01, 2'b01);
    wait_idle();
    checks += 2;
    if (cap_q.size() != 1) begin errors++; $display("FAIL coll_len: got %0d want 1", cap_q.size()); end
    if (cap_q.size() > 0 && cap_q[0] !== 8'h5A) begin errors++; $display("FAIL coll_pid: got %h want 5a", cap_q[0]); end

    start(1'b1, 1'b0, 2'b00, 2'b00);
    bus.send_data = 1'b1;
    bus.data_pid_sel = 2'b00;
    cycle();
    bus.send_data = 1'b0;
    wait_idle();
    repeat (3) cycle();
    checks += 3;
    if (cap_q.size() != 1) begin errors++; $display("FAIL busy_req_len: got %0d want 1", cap_q.size()); end
    if (cap_q.size() > 0 && cap_q[0] !== 8'hD2) begin errors++; $display("FAIL busy_req_pid: got %h want d2", cap_q[0]); end
    if (busy_cycles != 1 + IPG) begin errors++; $display("FAIL busy_req_busy: got %0d want %0d", busy_cycles, 1 + IPG); end
  endtask

  task automatic test_reset_mid_packet();
    payload.delete();
    for (int i = 0; i < 8; i++) payload.push_back(8'(8'hA0 + i));
    start(1'b0, 1'b1, 2'b00, 2'b00);
    repeat (3) cycle();
    checks += 6;
    if (dbg_state !== 3'd2) begin errors++; $display("FAIL rst_mid_in_data: got %0d want 2", dbg_state); end
    #2 rst_n = 1'b0;
    #1;
    if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", bus.tx_valid); end
    if (bus.tx_busy !== 1'b0)  begin errors++; $display("FAIL rst_mid_busy: got %b want 0", bus.tx_busy); end
    if (bus.tx_done !== 1'b0)  begin errors++; $display("FAIL rst_mid_done_now: got %b want 0", bus.tx_done); end
    if (done_cnt != 0)         begin errors++; $display("FAIL rst_mid_done: got %0d want 0", done_cnt); end
    if (cap_q.size() != 3)     begin errors++; $display("FAIL rst_mid_len: got %0d want 3", cap_q.size()); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    payload.delete();
    start(1'b1, 1'b0, 2'b00, 2'b00);
    wait_idle();
    checks += 2;
    if (cap_q.size() != 1 || cap_q[0] !== 8'hD2) begin
      errors++; $display("FAIL rst_after_ack: got %0d bytes first %h want 1 byte d2", cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : 8'hxx);
    end
    if (done_cnt != 1) begin errors++; $display("FAIL rst_after_done: got %0d want 1", done_cnt); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.send_token = 1'b0; bus.token_pid_sel = 2'b00;
    bus.send_data  = 1'b0; bus.data_pid_sel  = 2'b00;
    bus.tx_data_st = 8'h00; bus.tx_data_avail = 1'b0; bus.tx_ready = 1'b1;
    mem_idx = 0; mem_adv = 1'b0; stall_en = 1'b0; prev_stall = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_inputs();
    test_reset();
    test_handshake();
    test_data("zlp", 2'b00, 8'hC3, 0, 1'b0);
    test_data("data1", 2'b01, 8'h4B, 4, 1'b0);
    test_data("stall", 2'b01, 8'h4B, 4, 1'b1);
    test_data("mdata", 2'b11, 8'h0F, 9, 1'b1);
    test_collision();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
